bus_arbiter_rr: RTL and testbench

- Round-robin arbiter for the four bus masters (M0-M3) sharing the system bus.
- Drives the active-low grant lines. Also outputs the owner index that the bus master multiplexer uses to select address/As_/RW/WrData.
- Adds ownership hold, a dead cycle between owners, and a hold-limit preemption so one master (e.g. the CPU fetch port) cannot starve the others.

---
 rtl/bus_arbiter_rr_pkg.sv | 24 ++
 rtl/bus_arbiter_rr_if.sv | 30 +++
 rtl/rr_pick4.sv | 28 ++
 rtl/bus_arbiter_rr.sv | 114 +++++++++++
 tb/tb_bus_arbiter_rr.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared bus-arbiter definitions: owner index encoding, arbiter state encoding
// and a small one-hot helper used by the arbiter and its priority encoder.
package bus_arbiter_rr_pkg;

  localparam int BUS_OWNER_W = 2;
  localparam int BUS_MASTERS = 4;

  typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_M0 = 2'd0;
  localparam bus_owner_t BUS_OWNER_M1 = 2'd1;
  localparam bus_owner_t BUS_OWNER_M2 = 2'd2;
  localparam bus_owner_t BUS_OWNER_M3 = 2'd3;

  typedef enum logic [0:0] {
    ARB_STATE_IDLE  = 1'b0,
    ARB_STATE_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [BUS_MASTERS-1:0] owner_onehot(input bus_owner_t idx);
    return BUS_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the four bus masters and the round-robin arbiter.
// All request, strobe, ready and grant lines are active-low.
interface bus_arbiter_rr_if;
  import bus_arbiter_rr_pkg::*;

  logic       m0Req_, m1Req_, m2Req_, m3Req_;
  logic       m0As_,  m1As_,  m2As_,  m3As_;
  logic       mRdy_;
  logic       m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_;
  bus_owner_t owner;
  logic       ownerValid;
  logic       preempt;

  modport slave (
    input  m0Req_, m1Req_, m2Req_, m3Req_,
    input  m0As_,  m1As_,  m2As_,  m3As_,
    input  mRdy_,
    output m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_,
    output owner, ownerValid, preempt
  );

  modport master (
    output m0Req_, m1Req_, m2Req_, m3Req_,
    output m0As_,  m1As_,  m2As_,  m3As_,
    output mRdy_,
    input  m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_,
    input  owner, ownerValid, preempt
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way rotating priority encoder: first requester after last_i
// wins, searching last_i+1 .. last_i+4 (mod 4).
module rr_pick4
  import bus_arbiter_rr_pkg::*;
(
  input  logic [BUS_MASTERS-1:0] req_i,
  input  bus_owner_t             last_i,
  output bus_owner_t             winner_o,
  output logic                   any_o
);

  function automatic bus_owner_t rot(input bus_owner_t base, input int ofs);
    return base + bus_owner_t'(ofs);
  endfunction

  // Walk from the farthest offset down so the nearest requester is written last.
  always_comb begin
    winner_o = last_i;
    any_o    = 1'b0;
    for (int i = BUS_MASTERS; i >= 1; i--) begin
      if (req_i[rot(last_i, i)]) begin
        winner_o = rot(last_i, i);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for four bus masters: registered active-low grants, a dead
// cycle between owners, and hold-limit preemption that never cuts an access short.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int MAX_HOLD = 16,  // legal 2..255, with 2**HOLD_W > MAX_HOLD
  parameter int HOLD_W   = 8
) (
  input logic             clk,
  input logic             reset_,
  bus_arbiter_rr_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  arb_state_e             state_q, state_d;
  logic [BUS_MASTERS-1:0] grnt_q, grnt_d;
  bus_owner_t             owner_q, owner_d;
  bus_owner_t             last_q, last_d;
  logic                   ownerValid_q, ownerValid_d;
  logic                   preempt_q, preempt_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;

  logic [BUS_MASTERS-1:0] req;
  logic [BUS_MASTERS-1:0] as_n;
  bus_owner_t             winner;
  logic                   anyReq;
  logic                   ownReq, othersReq, inFlight, atLimit;

  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] cnt);
    return (cnt >= HOLD_MAX) ? cnt : cnt + HOLD_W'(1);
  endfunction

  assign req  = ~{bus.m3Req_, bus.m2Req_, bus.m1Req_, bus.m0Req_};
  assign as_n = {bus.m3As_, bus.m2As_, bus.m1As_, bus.m0As_};

  assign ownReq    = req[owner_q];
  assign othersReq = |(req & ~owner_onehot(owner_q));
  // An access is in flight while the owner strobes and the slave has not yet answered.
  assign inFlight  = ~as_n[owner_q] & bus.mRdy_;
  assign atLimit   = hold_q >= HOLD_LIM;

  rr_pick4 u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (winner),
    .any_o    (anyReq)
  );

  always_ff @(posedge clk) begin
    if (reset_) begin
      state_q      <= ARB_STATE_IDLE;
      grnt_q       <= '1;
      owner_q      <= BUS_OWNER_M0;
      last_q       <= BUS_OWNER_M3;
      ownerValid_q <= 1'b0;
      preempt_q    <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      grnt_q       <= grnt_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      ownerValid_q <= ownerValid_d;
      preempt_q    <= preempt_d;
      hold_q       <= hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grnt_d       = grnt_q;
    owner_d      = owner_q;
    last_d       = last_q;
    ownerValid_d = ownerValid_q;
    preempt_d    = 1'b0;
    hold_d       = hold_q;

    case (state_q)
      ARB_STATE_IDLE: begin
        grnt_d       = '1;
        ownerValid_d = 1'b0;
        if (anyReq) begin
          state_d      = ARB_STATE_GRANT;
          grnt_d       = ~owner_onehot(winner);
          owner_d      = winner;
          ownerValid_d = 1'b1;
          hold_d       = '0;
        end
      end
      ARB_STATE_GRANT: begin
        hold_d = hold_inc(hold_q);
        // Voluntary release takes precedence, so preempt only fires while the owner still requests.
        if (!ownReq || (atLimit && othersReq && !inFlight)) begin
          state_d      = ARB_STATE_IDLE;
          grnt_d       = '1;
          ownerValid_d = 1'b0;
          last_d       = owner_q;
          preempt_d    = ownReq;
        end
      end
    endcase
  end

  assign bus.m0Grnt_    = grnt_q[0];
  assign bus.m1Grnt_    = grnt_q[1];
  assign bus.m2Grnt_    = grnt_q[2];
  assign bus.m3Grnt_    = grnt_q[3];
  assign bus.owner      = owner_q;
  assign bus.ownerValid = ownerValid_q;
  assign bus.preempt    = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: each step drives inputs, queues the expected
// post-edge outputs and compares them one time unit after the rising edge.
module tb_bus_arbiter_rr;
  import bus_arbiter_rr_pkg::*;

  logic clk = 1'b0;
  logic reset_;

  bus_arbiter_rr_if bus();

  bus_arbiter_rr #(.MAX_HOLD(16), .HOLD_W(8)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] grnt;
    bus_owner_t owner;
    logic       vld;
    logic       pre;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_field(input string tag, input string fld,
                             input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    check_field(e.tag, "grnt", {bus.m3Grnt_, bus.m2Grnt_, bus.m1Grnt_, bus.m0Grnt_}, e.grnt);
    check_field(e.tag, "owner", {2'b00, bus.owner}, {2'b00, e.owner});
    check_field(e.tag, "ownerValid", {3'b000, bus.ownerValid}, {3'b000, e.vld});
    check_field(e.tag, "preempt", {3'b000, bus.preempt}, {3'b000, e.pre});
  endtask

  // Vectors are {m3,m2,m1,m0}, all active-low.
  task automatic step(input string tag, input logic rst, input logic [3:0] req_n,
                      input logic [3:0] as_n, input logic rdy_n,
                      input logic [3:0] grnt, input bus_owner_t owner,
                      input logic vld, input logic pre);
    exp_t e;
    reset_ = rst;
    {bus.m3Req_, bus.m2Req_, bus.m1Req_, bus.m0Req_} = req_n;
    {bus.m3As_, bus.m2As_, bus.m1As_, bus.m0As_}     = as_n;
    bus.mRdy_ = rdy_n;
    e.tag   = tag;
    e.grnt  = grnt;
    e.owner = owner;
    e.vld   = vld;
    e.pre   = pre;
    sb.push_back(e);
    @(posedge clk);
    #1;
    observe();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_owner_t w;
    logic [3:0] g;

    // Reset held with m0 requesting, then first grant goes to M0.
    for (int i = 0; i < 3; i++) step("reset", 1'b1, 4'hE, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0);
    step("first_m0", 1'b0, 4'hE, 4'hF, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);

    // M1 and M3 together from a fresh reset: M1 first, dead cycle, then M3.
    step("reset2", 1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0);
    step("m13_m1", 1'b0, 4'b0101, 4'hF, 1'b1, 4'b1101, 2'd1, 1'b1, 1'b0);
    step("m13_hold", 1'b0, 4'b0101, 4'hF, 1'b1, 4'b1101, 2'd1, 1'b1, 1'b0);
    step("m1_rel", 1'b0, 4'b0111, 4'hF, 1'b1, 4'hF, 2'd1, 1'b0, 1'b0);
    step("m3_gnt", 1'b0, 4'b0111, 4'hF, 1'b1, 4'b0111, 2'd3, 1'b1, 1'b0);
    step("m3_rel", 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 2'd3, 1'b0, 1'b0);
    step("idle", 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 2'd3, 1'b0, 1'b0);

    // All four request; each owner keeps the bus 3 cycles: order 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      w = bus_owner_t'(k % 4);
      g = ~(4'b0001 << w);
      step("rr_gnt", 1'b0, 4'h0, 4'hF, 1'b1, g, w, 1'b1, 1'b0);
      step("rr_hold", 1'b0, 4'h0, 4'hF, 1'b1, g, w, 1'b1, 1'b0);
      step("rr_hold", 1'b0, 4'h0, 4'hF, 1'b1, g, w, 1'b1, 1'b0);
      step("rr_rel", 1'b0, 4'b0001 << w, 4'hF, 1'b1, 4'hF, w, 1'b0, 1'b0);
    end

    // Hold-limit preemption of M0 by M2 (M2 requests from cycle 5).
    step("reset3", 1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0);
    step("pre_g0", 1'b0, 4'hE, 4'hF, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);
    for (int s = 2; s <= 16; s++)
      step("pre_hold", 1'b0, (s >= 6) ? 4'b1010 : 4'b1110, 4'hF, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);
    step("pre_rev", 1'b0, 4'b1010, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0, 1'b1);
    step("pre_m2", 1'b0, 4'b1010, 4'hF, 1'b1, 4'b1011, 2'd2, 1'b1, 1'b0);
    step("m2_rel", 1'b0, 4'b1110, 4'hF, 1'b1, 4'hF, 2'd2, 1'b0, 1'b0);
    step("m0_back", 1'b0, 4'b1110, 4'hF, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);
    step("m0_rel", 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0);

    // Same, but an access is in flight at the limit for 4 extra cycles.
    step("reset4", 1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0);
    step("acc_g0", 1'b0, 4'hE, 4'hF, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);
    for (int s = 2; s <= 16; s++)
      step("acc_pre", 1'b0, (s >= 6) ? 4'b1010 : 4'b1110, 4'hF, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);
    for (int x = 0; x < 4; x++)
      step("acc_inflight", 1'b0, 4'b1010, 4'b1110, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);
    step("acc_done", 1'b0, 4'b1010, 4'b1110, 1'b0, 4'hF, 2'd0, 1'b0, 1'b1);
    step("acc_m2", 1'b0, 4'b1010, 4'hF, 1'b1, 4'b1011, 2'd2, 1'b1, 1'b0);
    step("acc_m2_rel", 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 2'd2, 1'b0, 1'b0);

    // Release and preempt condition in the same cycle: release wins, no pulse.
    step("reset5", 1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0);
    step("rp_g0", 1'b0, 4'hE, 4'hF, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);
    for (int s = 2; s <= 16; s++)
      step("rp_hold", 1'b0, 4'b1100, 4'hF, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);
    step("rp_release", 1'b0, 4'b1101, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0);
    step("rp_m1", 1'b0, 4'b1101, 4'hF, 1'b1, 4'b1101, 2'd1, 1'b1, 1'b0);
    step("rp_m1_rel", 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 2'd1, 1'b0, 1'b0);

    // Sole requester is never preempted; reset mid-access revokes the grant.
    step("reset6", 1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0);
    step("solo_g0", 1'b0, 4'hE, 4'hF, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);
    for (int s = 2; s <= 19; s++)
      step("solo_hold", 1'b0, 4'hE, 4'hE, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);
    step("solo_reset", 1'b1, 4'hE, 4'hE, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0);
    for (int s = 21; s <= 40; s++)
      step("solo_after", 1'b0, 4'hE, 4'hF, 1'b1, 4'hE, 2'd0, 1'b1, 1'b0);
    step("solo_rel", 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
